// File: rtl/ntt_coef_tx.sv
// ntt_coef_tx: streams one polynomial (NUM_BEATS pairs of 23-bit coefficients)
// from a dual-port coefficient RAM into a 64-bit AXI-stream sink. Port A reads
// the even coefficient and port B the odd one, both in the same cycle. A
// 2-entry FIFO absorbs the 1-cycle RAM latency so that full tready gives one
// beat per cycle. Read issue is credit-limited so the FIFO can never overflow.
module ntt_coef_tx #(
  parameter int          NUM_BEATS = 128,
  parameter logic [7:0]  BASE_ADDR = 8'd0
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        coef_ena,
  output logic [7:0]  coef_addra,
  input  logic [22:0] coef_douta,
  output logic        coef_enb,
  output logic [7:0]  coef_addrb,
  input  logic [22:0] coef_doutb,
  output logic        Ws_tvalid,
  input  logic        Ws_tready,
  output logic [63:0] Ws_tdata,
  output logic [7:0]  Ws_tkeep,
  output logic        Ws_tlast
);

  // Read counter must hold NUM_BEATS itself ("all reads issued").
  localparam int            CW       = $clog2(NUM_BEATS + 1);
  localparam logic [CW-1:0] BEATS    = CW'(NUM_BEATS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  // Read side: beats issued so far, next even address, and the read whose
  // data appears on the RAM outputs this cycle.
  logic [CW-1:0] r_rd_cnt;
  logic [7:0]    r_addr;
  logic          r_pend;
  logic          r_pend_last;

  // Output FIFO: two packed beats with their tlast flags.
  logic [63:0]   r_fifo_data [2];
  logic [1:0]    r_fifo_last;
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;

  logic          w_pop;
  logic          w_issue;
  logic          w_head_last;
  logic [2:0]    w_occ;

  // ---------------------------------------------------------------------------
  // Handshake and read-credit logic
  // ---------------------------------------------------------------------------
  assign Ws_tvalid   = (r_count != 2'd0);
  assign w_pop       = Ws_tvalid && Ws_tready;
  assign w_head_last = r_fifo_last[r_rd_ptr];

  // Entries that will exist once this cycle's pop is taken, counting the read
  // already in flight. A new read may only be launched if it still fits.
  assign w_occ   = {1'b0, r_count} + {2'b0, r_pend} - {2'b0, w_pop};
  assign w_issue = (r_state == S_SEND) && (r_rd_cnt < BEATS) && (w_occ <= 3'd1);

  assign coef_ena   = w_issue;
  assign coef_enb   = w_issue;
  assign coef_addra = w_issue ? r_addr : 8'd0;
  assign coef_addrb = w_issue ? (r_addr + 8'd1) : 8'd0;

  // Head of the FIFO drives the stream; tlast is qualified by tvalid so a
  // stale flag in an empty slot never shows.
  assign Ws_tdata = r_fifo_data[r_rd_ptr];
  assign Ws_tlast = Ws_tvalid && w_head_last;
  assign Ws_tkeep = 8'hFF;

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: start only counts in IDLE; SEND ends on the tlast beat.
  // NOTE: the default assignment first keeps this block free of inferred
  // latches on paths that do not change state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_SEND;
      S_SEND: if (w_pop && w_head_last) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read issue
  // ---------------------------------------------------------------------------

  // Beat counter and address pointer; reloaded when a new send is accepted.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_cnt    <= '0;
      r_addr      <= BASE_ADDR;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_rd_cnt <= '0;
        r_addr   <= BASE_ADDR;
      end else if (w_issue) begin
        r_rd_cnt <= r_rd_cnt + CW'(1);
        r_addr   <= r_addr + 8'd2;
      end
      r_pend      <= w_issue;
      r_pend_last <= w_issue && (r_rd_cnt == LAST_IDX);
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------

  // Capture RAM data one cycle after the read and retire the head on handshake.
  // NOTE: the two storage entries are reset as well, because the stream data
  // output must read 0 out of reset and is driven straight from this storage.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last    <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_count        <= 2'd0;
    end else begin
      if (r_pend) begin
        r_fifo_data[r_wr_ptr] <= {9'b0, coef_doutb, 9'b0, coef_douta};
        r_fifo_last[r_wr_ptr] <= r_pend_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, r_pend} - {1'b0, w_pop};
    end
  end

endmodule
